// File: rtl/serial_sub_pkg.sv
// Shared constants and FSM encoding for the bit-serial subtractor.
// The SERIAL_SUB_OVF_EN build option is handled in serial_subtractor.sv.
package serial_sub_pkg;

  localparam int SUB_DEF_N = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial subtractor, one bit per SHIFT cycle.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = SUB_DEF_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic         ovf,
`endif
  output logic         bout
);

  localparam int CW = $clog2(N) + 1;

  state_t         r_state;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_sh;
  logic [N-1:0]   r_diff;
  logic           r_br;
  logic           r_busy;
  logic           r_done;
  logic           r_bout;
  logic [CW-1:0]  r_cnt;
  logic           w_d;
  logic           w_bo;
`ifdef SERIAL_SUB_OVF_EN
  logic           r_amsb;
  logic           r_bmsb;
  logic           r_ovf;
`endif

  full_subtractor u_fs (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .bi (r_br),
    .d  (w_d),
    .bo (w_bo)
  );

  // Outputs are registered, so they trail the state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sh    <= '0;
      r_diff  <= '0;
      r_br    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bout  <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_busy <= (r_state != IDLE);
      r_done <= (r_state == DONE);
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_sh    <= '0;
            r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_amsb  <= a[N-1];
            r_bmsb  <= b[N-1];
`endif
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_sh  <= {w_d, r_sh[N-1:1]};
          r_br  <= w_bo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(N - 1))
            r_state <= DONE;
        end
        DONE: begin
          r_diff  <= r_sh;
          r_bout  <= r_br;
`ifdef SERIAL_SUB_OVF_EN
          r_ovf   <= (r_amsb != r_bmsb) && (r_sh[N-1] != r_amsb);
`endif
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at N=4.
// Overflow checks are compiled in with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_run  = 0;
  int n_fail = 0;

  serial_subtractor #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf   (ovf),
`endif
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one operation, then scrambles or churns the inputs while it runs.
  task automatic run_op(input string tag, input logic [N-1:0] va,
                        input logic [N-1:0] vb, input logic vbin,
                        input logic [N-1:0] ed, input logic eb,
                        input logic eo, input bit hold);
    int cyc;
    int bcnt;
    int extra;
    bit got;
    cyc  = 0;
    bcnt = 0;
    got  = 1'b0;
    @(negedge clk);
    a = va; b = vb; bin = vbin; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    a = ~va; b = ~vb; bin = ~vbin;
    while (!got && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) bcnt++;
      if (done) got = 1'b1;
      if (hold && cyc == 2) begin
        a = va + 4'd3;
        b = vb ^ 4'h5;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, cyc, N + 1);
    check({tag, "_busy_cycles"}, bcnt, N + 1);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) check({tag, "_eo_known"}, 32'(eo), 32'd0);
`endif
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_diff_hold"}, 32'(diff), 32'(ed));
    if (hold) begin
      extra = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        if (done) extra++;
      end
      check({tag, "_extra_done"}, extra, 0);
    end
  endtask

  initial begin
    int dn;
    rst_n = 1'b1;
    start = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("v1", 4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    run_op("v2", 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    run_op("v3", 4'b1010, 4'b0110, 1'b1, 4'b0011, 1'b0, 1'b1, 1'b0);
    run_op("v4", 4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);
    run_op("v5", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    run_op("v6", 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0);
    run_op("hold", 4'b1001, 4'b0100, 1'b0, 4'b0101, 1'b0, 1'b1, 1'b1);
    run_op("v7", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);

    // Abort an operation mid-shift; outputs must clear without a clock.
    @(negedge clk);
    a = 4'b0101; b = 4'b0011; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_bout", 32'(bout), 32'd0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
      if (i == 3) rst_n = 1'b1;
    end
    check("mid_rst_no_done", dn, 0);
    run_op("post_rst", 4'b1100, 4'b0101, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
